pid_encoder_v: RTL and testbench
================================

# pid_encoder_v

Per-channel quadrature encoder front end and error generator that sits directly upstream of the multi-channel PID controller. It decodes `an` raw A/B encoder phase pairs into signed position counters and holds a CPU-written setpoint for each channel. It presents `error = setpoint - position`, saturated to `ew` bits, for whichever channel the PID controller currently addresses on `a`. It also provides position readback and illegal-transition flags for the CPU bus.

## Interface
- `aw`, 1: address width; the number of channels is `an = 2^aw`.
- `an`, `1<<aw`: number of channels (derived).
- `ew`, 24: width of the setpoint, the position counter and the error output (signed two's complement).
- `clk_pid`  in  1  — PID domain clock; all state is updated on its rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `enc_a`  in  an  — raw encoder phase A per channel, asynchronous to `clk_pid`.
- `enc_b`  in  an  — raw encoder phase B per channel, asynchronous to `clk_pid`.
- `sp_we`  in  1  — setpoint write strobe (one cycle).
- `sp_addr`  in  aw  — channel addressed by both setpoint write and readback.
- `sp_data`  in  ew  — signed setpoint value to write.
- `pos_clr`  in  an  — per-channel synchronous clear of the position counter and its error flag.
- `a`  in  aw  — channel address driven by the PID controller.
- `error`  out  ew  — registered, saturated `sp[a] - pos[a]`.
- `pos_rd`  out  ew  — registered `pos[sp_addr]`, for CPU readback.
- `enc_err`  out  an  — sticky per-channel flag marking an illegal quadrature transition.

## Operation
- **Synchroniser.** Each `enc_a`/`enc_b` bit passes through a 2-flop synchroniser. A third register holds the previous synchronised pair `{A,B}` for each channel.
- **Arming.** After `reset` deasserts, a 2-bit arm counter runs for 3 cycles. Decoding is disabled while it runs: the previous-state registers load only, and no count or flag changes occur. This prevents a false count or flag when the inputs are not at 00 when reset releases.
- **4x decode.** Forward sequence is 00→10→11→01→00 (A leads B); each forward step does `pos += 1`.
  - The reverse sequence does `pos -= 1`.
  - No change: hold.
  - Both bits changing in one cycle is illegal: the counter holds and `enc_err[i]` is set.
- **Counter width.** `pos` is `ew` bits and wraps in two's complement: 0x7FFFFF + 1 gives 0x800000 (for `ew=24`).
- **Clear priority.** `pos_clr[i]` zeroes `pos[i]` and `enc_err[i]` and takes priority over a decode step in the same cycle.
- **Setpoint write.** When `sp_we` is high, `sp[sp_addr] <= sp_data`. A setpoint write is independent of decoding, so both may occur in the same cycle.
- **Error computation.** The difference is formed at `ew+1` bits:
  - if it is above `2^(ew-1)-1`, `error` takes that value;
  - if it is below `-2^(ew-1)`, `error` takes `-2^(ew-1)`;
  - otherwise `error` takes the difference.
  - Saturation prevents the PID from seeing sign inversion when the counter wraps.
- **Readback.** `pos_rd <= pos[sp_addr]` every cycle.
- **Reset values.** All `pos`, `sp`, `error`, `pos_rd`, `enc_err`, synchroniser and previous-state registers are 0, and the arm counter is 0.
- **Reset mid-operation.** Reset asserted at any time immediately clears everything, and arming restarts after release.

## Timing
- **Encoder edge to count.**
  - Input edge, then 2 cycles of synchroniser.
  - Cycle 3: decode, after which `pos` is updated.
  - Cycle 4: `error` and `pos_rd` reflect the new count.
  - Total: 4 cycles from the edge to `error`.
- **Setpoint write to error.** `sp_we` in cycle n updates `sp` at the edge ending n. `error` reflects the new value after the edge ending n+1, provided `a == sp_addr`.
- **Address change to error.** `a` changing in cycle n gives valid `error` for the new channel after the edge ending n. The PID holds `a` for far longer than 1 cycle before sampling.
- **Maximum encoder rate.** One legal transition per 2 `clk_pid` cycles per channel. Faster inputs produce illegal-transition flags rather than silent miscounts.
- **Output stability.** All outputs are registered, and none is combinational from any input.

## Test plan
- **Reset and arming.** Hold `enc_a=enc_b=1` on channel 0 through reset release → `pos[0]` stays 0 and `enc_err[0]` stays 0 through arming and afterwards.
- **Forward and reverse counting.** Drive 10 full forward cycles (40 steps) on channel 1, then 15 reverse steps → `pos_rd` reads 25 with `sp_addr=1`. With `sp[1]=100` and `a=1`, `error` = 75.
- **Illegal transition.** Jump channel 0 from 00 to 11 in one sample → `enc_err[0]=1` and the count is unchanged. Pulse `pos_clr[0]` → flag and count become 0. Assert `pos_clr` in the same cycle as a step → result is 0.
- **Saturation and wrap.**
  - Set `sp=0x7FFFFF` and `pos=-2` (2 reverse steps from 0) → `error` saturates at 0x7FFFFF.
  - Set `sp=0x800000` and `pos=+1` → `error` = 0x800000.
  - Count forward past 0x7FFFFF → `pos` wraps to 0x800000.
- **Setpoint latency and channel isolation.** Write `sp[1]=-500` while `a=0` → `error` unchanged. Switch to `a=1` → `error=-500-pos[1]` on the next cycle. Assert reset mid-count → all outputs are 0 on the following edge.

Source files
------------

// File: rtl/pid_encoder_v.sv
// Quadrature encoder front end for the multi-channel PID: per-channel 4x decode into
// wrapping position counters, CPU setpoints, and a saturated setpoint-minus-position error.
module pid_encoder_v #(
   parameter int aw = 1,
   parameter int ew = 24,
   localparam int an = 1 << aw
) (
   input  logic                 clk_pid,
   input  logic                 reset,
   input  logic [an-1:0]        enc_a,
   input  logic [an-1:0]        enc_b,
   input  logic                 sp_we,
   input  logic [aw-1:0]        sp_addr,
   input  logic [ew-1:0]        sp_data,
   input  logic [an-1:0]        pos_clr,
   input  logic [aw-1:0]        a,
   output logic [ew-1:0]        error,
   output logic [ew-1:0]        pos_rd,
   output logic [an-1:0]        enc_err
);

   localparam logic [ew-1:0] one_c = {{(ew-1){1'b0}}, 1'b1};

   logic [an-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q, a_prev_q, b_prev_q;
   logic [1:0]    arm_q, arm_d;
   logic [ew-1:0] pos_q [an];
   logic [ew-1:0] pos_d [an];
   logic [ew-1:0] sp_q  [an];
   logic [ew-1:0] sp_d  [an];
   logic [an-1:0] enc_err_q, enc_err_d;
   logic [ew-1:0] error_q, error_d, pos_rd_q, pos_rd_d;

   // Maps {A,B} onto a Gray-code ring position so one subtraction classifies a transition.
   function automatic logic [1:0] quad_idx(input logic pa, input logic pb);
      return {pb, pa ^ pb};
   endfunction

   function automatic logic [ew-1:0] sat_diff(input logic [ew-1:0] s, input logic [ew-1:0] p);
      logic [ew:0] d;
      d = {s[ew-1], s} - {p[ew-1], p};
      if (d[ew] != d[ew-1]) begin
         if (d[ew]) begin
            return {1'b1, {(ew-1){1'b0}}};
         end else begin
            return {1'b0, {(ew-1){1'b1}}};
         end
      end else begin
         return d[ew-1:0];
      end
   endfunction

   // Arming, decode, clear and setpoint next-state.
   always_comb begin
      arm_d = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
      for (int i = 0; i < an; i++) begin
         pos_d[i]     = pos_q[i];
         enc_err_d[i] = enc_err_q[i];
         if (pos_clr[i]) begin
            pos_d[i]     = {ew{1'b0}};
            enc_err_d[i] = 1'b0;
         end else if (arm_q == 2'd3) begin
            case (quad_idx(a_s2_q[i], b_s2_q[i]) - quad_idx(a_prev_q[i], b_prev_q[i]))
               2'd1:    pos_d[i]     = pos_q[i] + one_c;
               2'd3:    pos_d[i]     = pos_q[i] - one_c;
               2'd2:    enc_err_d[i] = 1'b1;
               default: pos_d[i]     = pos_q[i];
            endcase
         end else begin
            pos_d[i] = pos_q[i];
         end
         if (sp_we && (sp_addr == aw'(i))) begin
            sp_d[i] = sp_data;
         end else begin
            sp_d[i] = sp_q[i];
         end
      end
   end

   // Output next-state: saturated error for the PID channel and CPU readback.
   always_comb begin
      error_d  = sat_diff(sp_q[a], pos_q[a]);
      pos_rd_d = pos_q[sp_addr];
   end

   // State registers.
   always_ff @(posedge clk_pid or posedge reset) begin
      if (reset) begin
         a_s1_q    <= {an{1'b0}};
         a_s2_q    <= {an{1'b0}};
         b_s1_q    <= {an{1'b0}};
         b_s2_q    <= {an{1'b0}};
         a_prev_q  <= {an{1'b0}};
         b_prev_q  <= {an{1'b0}};
         arm_q     <= 2'd0;
         enc_err_q <= {an{1'b0}};
         error_q   <= {ew{1'b0}};
         pos_rd_q  <= {ew{1'b0}};
         for (int i = 0; i < an; i++) begin
            pos_q[i] <= {ew{1'b0}};
            sp_q[i]  <= {ew{1'b0}};
         end
      end else begin
         a_s1_q    <= enc_a;
         a_s2_q    <= a_s1_q;
         b_s1_q    <= enc_b;
         b_s2_q    <= b_s1_q;
         a_prev_q  <= a_s2_q;
         b_prev_q  <= b_s2_q;
         arm_q     <= arm_d;
         enc_err_q <= enc_err_d;
         error_q   <= error_d;
         pos_rd_q  <= pos_rd_d;
         for (int i = 0; i < an; i++) begin
            pos_q[i] <= pos_d[i];
            sp_q[i]  <= sp_d[i];
         end
      end
   end

   assign error   = error_q;
   assign pos_rd  = pos_rd_q;
   assign enc_err = enc_err_q;

endmodule

// File: tb/tb_pid_encoder_v.sv
// Scoreboard bench for pid_encoder_v: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pid_encoder_v;

   logic        clk_pid = 1'b0;
   logic        reset;
   logic [1:0]  enc_a, enc_b, pos_clr;
   logic        sp_we, sp_addr, a;
   logic [23:0] sp_data, error, pos_rd;
   logic [1:0]  enc_err;
   logic [3:0]  w_error, w_pos_rd;
   logic [1:0]  w_enc_err;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t        exp_q[$];
   int          checks = 0;
   int          fails  = 0;
   logic [1:0]  cur_ab [2];

   pid_encoder_v #(.aw(1), .ew(24)) dut (
      .clk_pid(clk_pid), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .sp_we(sp_we), .sp_addr(sp_addr), .sp_data(sp_data), .pos_clr(pos_clr),
      .a(a), .error(error), .pos_rd(pos_rd), .enc_err(enc_err)
   );

   // Narrow instance sharing the encoder inputs, used to reach the counter wrap point quickly.
   pid_encoder_v #(.aw(1), .ew(4)) dut_w (
      .clk_pid(clk_pid), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .sp_we(1'b0), .sp_addr(1'b1), .sp_data(4'h0), .pos_clr(2'b00),
      .a(1'b1), .error(w_error), .pos_rd(w_pos_rd), .enc_err(w_enc_err)
   );

   initial forever #5 clk_pid = ~clk_pid;

   function automatic logic [1:0] fwd_next(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] rev_next(input logic [1:0] s);
      case (s)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] get_act(input int sel);
      case (sel)
         0:       return {8'h00, error};
         1:       return {8'h00, pos_rd};
         2:       return {30'h0, enc_err};
         3:       return {28'h0, w_error};
         4:       return {28'h0, w_pos_rd};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_pid);
      #1;
   endtask

   task automatic expect_out(input int sel, input logic [31:0] exp, input string name);
      chk_t c;
      c.sel = sel; c.exp = exp; c.name = name;
      exp_q.push_back(c);
   endtask

   task automatic drive(input int ch);
      enc_a[ch] = cur_ab[ch][1];
      enc_b[ch] = cur_ab[ch][0];
   endtask

   task automatic move(input int ch, input bit fwd, input int n);
      for (int i = 0; i < n; i++) begin
         cur_ab[ch] = fwd ? fwd_next(cur_ab[ch]) : rev_next(cur_ab[ch]);
         drive(ch);
         tick(2);
      end
   endtask

   task automatic write_sp(input logic ch, input logic [23:0] d);
      sp_addr = ch;
      sp_data = d;
      sp_we   = 1'b1;
      tick(1);
      sp_we   = 1'b0;
   endtask

   // Monitor: compares every queued expectation against the settled outputs.
   initial forever begin
      @(negedge clk_pid);
      while (exp_q.size() != 0) begin
         chk_t c;
         logic [31:0] act;
         c   = exp_q.pop_front();
         act = get_act(c.sel);
         checks++;
         if (act !== c.exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", c.name, act, c.exp);
         end
      end
   end

   initial begin
      reset = 1'b1; sp_we = 1'b0; sp_addr = 1'b0; sp_data = 24'h0; a = 1'b0; pos_clr = 2'b00;
      cur_ab[0] = 2'b11; cur_ab[1] = 2'b00;
      drive(0); drive(1);
      tick(3);
      expect_out(0, 32'h0, "reset_error");
      expect_out(1, 32'h0, "reset_pos_rd");
      expect_out(2, 32'h0, "reset_enc_err");
      tick(1);
      reset = 1'b0;
      tick(1);
      expect_out(2, 32'h0, "arming_enc_err");
      tick(8);
      expect_out(1, 32'h0, "armed_pos0");
      expect_out(2, 32'h0, "armed_enc_err");

      // Forward/reverse counting on channel 1, with a wrap check on the narrow instance.
      sp_addr = 1'b1; a = 1'b1;
      move(1, 1'b1, 8);
      tick(4);
      expect_out(1, 32'd8, "fwd8_pos_rd");
      expect_out(0, 32'h00FF_FFF8, "fwd8_error");
      expect_out(4, 32'h8, "narrow_wrap_pos");
      expect_out(3, 32'h7, "narrow_wrap_sat");
      move(1, 1'b1, 32);
      move(1, 1'b0, 15);
      write_sp(1'b1, 24'd100);
      tick(3);
      expect_out(1, 32'd25, "fwdrev_pos_rd");
      expect_out(0, 32'd75, "fwdrev_error");

      // Illegal transition and clear on channel 0.
      sp_addr = 1'b0;
      move(0, 1'b0, 2);
      tick(4);
      expect_out(1, 32'h00FF_FFFE, "ch0_minus2");
      cur_ab[0] = 2'b11; drive(0);
      tick(6);
      expect_out(2, 32'h1, "illegal_flag");
      expect_out(1, 32'h00FF_FFFE, "illegal_hold");
      pos_clr = 2'b01; tick(1); pos_clr = 2'b00;
      tick(3);
      expect_out(2, 32'h0, "clr_flag");
      expect_out(1, 32'h0, "clr_pos");
      cur_ab[0] = fwd_next(cur_ab[0]); drive(0);
      tick(2);
      pos_clr = 2'b01; tick(1); pos_clr = 2'b00;
      tick(4);
      expect_out(1, 32'h0, "clr_beats_step");

      // Saturation at both rails.
      a = 1'b0;
      move(0, 1'b0, 2);
      write_sp(1'b0, 24'h7F_FFFF);
      tick(4);
      expect_out(1, 32'h00FF_FFFE, "sat_hi_pos");
      expect_out(0, 32'h007F_FFFF, "sat_hi_error");
      move(0, 1'b1, 3);
      write_sp(1'b0, 24'h80_0000);
      tick(4);
      expect_out(1, 32'd1, "sat_lo_pos");
      expect_out(0, 32'h0080_0000, "sat_lo_error");

      // Setpoint isolation and address switch.
      write_sp(1'b1, 24'hFF_FE0C);
      tick(3);
      expect_out(0, 32'h0080_0000, "isolation_error");
      a = 1'b1;
      tick(1);
      expect_out(0, 32'h00FF_FDF3, "switch_error");
      expect_out(1, 32'd25, "switch_pos_rd");
      tick(2);

      // Reset mid-count, then rearm with a non-zero input pair.
      cur_ab[1] = fwd_next(cur_ab[1]); drive(1);
      tick(2);
      #2 reset = 1'b1;
      expect_out(0, 32'h0, "midreset_error");
      expect_out(1, 32'h0, "midreset_pos_rd");
      expect_out(2, 32'h0, "midreset_enc_err");
      tick(2);
      reset = 1'b0;
      tick(10);
      expect_out(1, 32'h0, "rearm_pos_rd");
      expect_out(0, 32'h0, "rearm_error");
      expect_out(4, 32'h0, "rearm_narrow_pos");

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick(1);
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
